// File: rtl/mca_s_sequencer_pkg.sv
// Shared types and timing constants for the MCA control-stream sequencer.
// The default adder latency follows the two-stage tree depth plus pipeline margin.
package mca_s_sequencer_pkg;

    localparam int MCA_NUM_ADDITIONS     = 16;
    localparam int ADDER_LATENCY_DEFAULT = 2 * MCA_NUM_ADDITIONS + 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } seq_state_t;

    // Width needed to hold a latency count from 0 up to and including lat.
    function automatic int lat_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mca_s_sequencer_s_shift_window.sv
// K_MAX-deep shift register of accepted control bits; index 0 holds the newest bit.
// window_next is the value the register takes at the coming edge.
module s_shift_window #(
    parameter int K_MAX = 512
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_in,
    input  logic             s_valid,
    output logic [K_MAX-1:0] window,
    output logic [K_MAX-1:0] window_next
);

    always_comb begin
        window_next = window;
        if (s_valid) begin
            window_next = {window[K_MAX-2:0], s_in};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            window <= '0;
        end else begin
            window <= window_next;
        end
    end

endmodule

// File: rtl/mca_s_sequencer.sv
// Decimation sequencer: counts accepted control bits, snapshots the window every OSR bits,
// starts the accumulator and captures its result after the adder-tree latency.
module mca_s_sequencer
    import mca_s_sequencer_pkg::*;
#(
    parameter int K_MAX             = 512,
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int OSR_WIDTH         = 8,
    parameter int ADDER_LATENCY     = ADDER_LATENCY_DEFAULT
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                s_in,
    input  logic                                s_valid,
    input  logic [OSR_WIDTH-1:0]                osr,
    output logic [K_MAX-1:0]                    S_matrix,
    output logic                                start,
    input  logic signed [WIDTH_COEFFICIENT-1:0] sample_in,
    output logic signed [WIDTH_COEFFICIENT-1:0] sample_out,
    output logic                                sample_valid,
    output logic                                busy,
    output logic                                overrun,
    output logic                                dbg_state,
    output logic [K_MAX-1:0]                    dbg_window
);

    localparam int                LAT_W    = lat_width(ADDER_LATENCY);
    localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(ADDER_LATENCY);
    localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);

    seq_state_t             state, state_next;
    logic [LAT_W-1:0]       lat, lat_next;
    logic [OSR_WIDTH-1:0]   cnt, cnt_next, osr_eff;
    logic                   trigger;
    logic                   start_next, sample_valid_next, overrun_next;
    logic                   snap, capture;
    logic [K_MAX-1:0]       window_next;

    s_shift_window #(
        .K_MAX (K_MAX)
    ) u_window (
        .clk         (clk),
        .resetn      (resetn),
        .s_in        (s_in),
        .s_valid     (s_valid),
        .window      (dbg_window),
        .window_next (window_next)
    );

    // ">=" rather than "==" so a mid-count osr decrease fires on the next accepted bit.
    always_comb begin
        osr_eff  = (osr == '0) ? OSR_WIDTH'(1) : osr;
        trigger  = s_valid && (cnt >= (osr_eff - OSR_WIDTH'(1)));
        cnt_next = cnt;
        if (s_valid) begin
            cnt_next = trigger ? '0 : cnt + OSR_WIDTH'(1);
        end
    end

    always_comb begin
        state_next        = state;
        lat_next          = lat;
        start_next        = 1'b0;
        sample_valid_next = 1'b0;
        overrun_next      = overrun;
        snap              = 1'b0;
        capture           = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    snap       = 1'b1;
                    start_next = 1'b1;
                    lat_next   = LAT_LOAD;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                lat_next = lat - LAT_ONE;
                if (lat == LAT_ONE) begin
                    capture           = 1'b1;
                    sample_valid_next = 1'b1;
                    // A trigger landing on completion is accepted back-to-back.
                    if (trigger) begin
                        snap       = 1'b1;
                        start_next = 1'b1;
                        lat_next   = LAT_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (trigger) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            lat          <= '0;
            cnt          <= '0;
            start        <= 1'b0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            S_matrix     <= '0;
            sample_out   <= '0;
        end else begin
            state        <= state_next;
            lat          <= lat_next;
            cnt          <= cnt_next;
            start        <= start_next;
            sample_valid <= sample_valid_next;
            overrun      <= overrun_next;
            if (snap) begin
                S_matrix <= window_next;
            end
            if (capture) begin
                sample_out <= sample_in;
            end
        end
    end

    assign busy      = (state == BUSY);
    assign dbg_state = state;

endmodule

// File: tb/tb_mca_s_sequencer.sv
// Directed bench for mca_s_sequencer: scenario table with hand-computed timing,
// plus hand-written sequences for osr lowering and reset during BUSY.
module tb_mca_s_sequencer;

    localparam int K_MAX = 512;
    localparam int W     = 32;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                s_in = 1'b0;
    logic                s_valid = 1'b0;
    logic [7:0]          osr = 8'd0;
    logic [K_MAX-1:0]    S_matrix;
    logic                start;
    logic signed [W-1:0] sample_in = '0;
    logic signed [W-1:0] sample_out;
    logic                sample_valid;
    logic                busy;
    logic                overrun;
    logic                dbg_state;
    logic [K_MAX-1:0]    dbg_window;

    int errors = 0;
    int checks = 0;

    mca_s_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_in         (s_in),
        .s_valid      (s_valid),
        .osr          (osr),
        .S_matrix     (S_matrix),
        .start        (start),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun),
        .dbg_state    (dbg_state),
        .dbg_window   (dbg_window)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [K_MAX-1:0] act, input logic [K_MAX-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_in    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Apply inputs for edge e, then sample the outputs 1 time unit after that edge.
    task automatic step(input int e, input int period);
        s_valid   = ((e - 1) % period) == 0;
        s_in      = (e % 2) == 1;
        sample_in = 32'hA500_0000 | e;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  osr;
        int          period;
        int          ncyc;
        int          exp_starts;
        int          exp_first;
        int          exp_second;
        int          exp_sv;
        logic [31:0] exp_first_sample;
        int          exp_idle;
        logic        exp_overrun;
        logic [63:0] exp_snap;
    } vec_t;

    vec_t vecs[5];

    int               n_start, first_start, second_start, n_sv, idle_cnt, bad_snap;
    logic [31:0]      first_sample;
    logic [K_MAX-1:0] first_snap, prev_snap;

    initial begin
        vecs[0] = '{8'd40, 1, 130, 3, 40,  80,  2, 32'hA500_004A, 12, 1'b0, 64'h0000_00AA_AAAA_AAAA};
        vecs[1] = '{8'd40, 2, 170, 2, 79,  159, 1, 32'hA500_0071, 46, 1'b0, 64'h0000_00FF_FFFF_FFFF};
        vecs[2] = '{8'd10, 1, 60,  2, 10,  50,  1, 32'hA500_002C, 6,  1'b1, 64'h0000_0000_0000_02AA};
        vecs[3] = '{8'd34, 1, 110, 3, 34,  68,  2, 32'hA500_0044, 0,  1'b0, 64'h0000_0002_AAAA_AAAA};
        vecs[4] = '{8'd0,  1, 40,  2, 1,   35,  1, 32'hA500_0023, 0,  1'b1, 64'h0000_0000_0000_0001};

        // Reset values
        osr = 8'd40;
        reset_dut();
        check("reset_start",        K_MAX'(start),        '0);
        check("reset_sample_valid", K_MAX'(sample_valid), '0);
        check("reset_busy",         K_MAX'(busy),         '0);
        check("reset_overrun",      K_MAX'(overrun),      '0);
        check("reset_sample_out",   K_MAX'(sample_out),   '0);
        check("reset_S_matrix",     S_matrix,             '0);

        // Scenario table
        for (int v = 0; v < 5; v++) begin
            osr = vecs[v].osr;
            reset_dut();
            n_start = 0; first_start = 0; second_start = 0; n_sv = 0;
            idle_cnt = 0; bad_snap = 0; first_sample = '0; first_snap = '0;
            prev_snap = S_matrix;
            for (int e = 1; e <= vecs[v].ncyc; e++) begin
                step(e, vecs[v].period);
                if (first_start != 0 && !busy) idle_cnt++;
                if (start) begin
                    n_start++;
                    if (first_start == 0) begin
                        first_start = e;
                        first_snap  = S_matrix;
                    end else if (second_start == 0) begin
                        second_start = e;
                    end
                end else if (S_matrix !== prev_snap) begin
                    bad_snap++;
                end
                prev_snap = S_matrix;
                if (sample_valid) begin
                    if (n_sv == 0) first_sample = sample_out;
                    n_sv++;
                end
            end
            check($sformatf("v%0d_starts", v),       K_MAX'(n_start),      K_MAX'(vecs[v].exp_starts));
            check($sformatf("v%0d_first_start", v),  K_MAX'(first_start),  K_MAX'(vecs[v].exp_first));
            check($sformatf("v%0d_second_start", v), K_MAX'(second_start), K_MAX'(vecs[v].exp_second));
            check($sformatf("v%0d_sample_valids", v), K_MAX'(n_sv),        K_MAX'(vecs[v].exp_sv));
            check($sformatf("v%0d_first_sample", v), K_MAX'(first_sample), K_MAX'(vecs[v].exp_first_sample));
            check($sformatf("v%0d_idle_cycles", v),  K_MAX'(idle_cnt),     K_MAX'(vecs[v].exp_idle));
            check($sformatf("v%0d_overrun", v),      K_MAX'(overrun),      K_MAX'(vecs[v].exp_overrun));
            check($sformatf("v%0d_snapshot", v),     first_snap,           K_MAX'(vecs[v].exp_snap));
            check($sformatf("v%0d_snap_stable", v),  K_MAX'(bad_snap),     '0);
        end

        // Lowering osr from 100 to 5 with cnt at 50 fires on the next accepted bit
        osr = 8'd100;
        reset_dut();
        n_start = 0; first_start = 0;
        for (int e = 1; e <= 51; e++) begin
            if (e == 51) osr = 8'd5;
            step(e, 1);
            if (start) begin
                n_start++;
                if (first_start == 0) first_start = e;
            end
        end
        check("osr_lower_first_start", K_MAX'(first_start), K_MAX'(51));
        check("osr_lower_starts",      K_MAX'(n_start),     K_MAX'(1));

        // Reset while BUSY with lat at 10 (trigger at edge 20, osr 20)
        osr = 8'd20;
        reset_dut();
        for (int e = 1; e <= 44; e++) step(e, 1);
        check("midbusy_busy_before", K_MAX'(busy), K_MAX'(1));
        #1 resetn = 1'b0;
        #1;
        check("midbusy_rst_busy",    K_MAX'(busy),         '0);
        check("midbusy_rst_start",   K_MAX'(start),        '0);
        check("midbusy_rst_sv",      K_MAX'(sample_valid), '0);
        check("midbusy_rst_S",       S_matrix,             '0);
        check("midbusy_rst_sample",  K_MAX'(sample_out),   '0);
        @(negedge clk);
        resetn = 1'b1;
        n_start = 0; first_start = 0; n_sv = 0;
        for (int e = 1; e <= 25; e++) begin
            step(e, 1);
            if (sample_valid) n_sv++;
            if (start) begin
                n_start++;
                if (first_start == 0) first_start = e;
            end
        end
        check("midbusy_no_sample_valid", K_MAX'(n_sv),        '0);
        check("midbusy_restart_edge",    K_MAX'(first_start), K_MAX'(20));
        check("midbusy_restart_count",   K_MAX'(n_start),     K_MAX'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
